program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, program address width in bits (4..32).
REQ-002 Parameter RAS_DEPTH, default 4, return-address stack entries (power of two, 2..16).
REQ-003 Parameter RESET_ADDR, default 0, address loaded on reset.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  advance strobe; when low, the sequencer holds all state.
REQ-007 op  input  3  operation select: 000 INC, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET, 101-111 HOLD.
REQ-008 target  input  ADDR_W  absolute destination for JUMP and CALL.
REQ-009 offset  input  ADDR_W  two's-complement relative displacement for BRANCH.
REQ-010 address  output  ADDR_W  registered current program address.
REQ-011 depth  output  clog2(RAS_DEPTH+1)  number of valid stack entries.
REQ-012 stack_full / stack_empty  output  1 each  depth==RAS_DEPTH / depth==0; combinational from depth.
REQ-013 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-014 With enable=0 the sequencer SHALL hold address, stack contents, depth and flags, whatever op is.
REQ-015 With enable=1, one op SHALL execute per cycle; the new address SHALL be visible one edge after sampling (latency 1).
REQ-016 INC: address <= address+1 modulo 2^ADDR_W; all-ones wraps to 0 with no flag.
REQ-017 JUMP: address <= target.
REQ-018 BRANCH: address <= address+offset modulo 2^ADDR_W (offset all-ones = -1; offset 0 = self-loop).
REQ-019 CALL: push (address+1) mod 2^ADDR_W; address <= target; depth+1.
REQ-020 CALL while stack_full: the oldest entry SHALL be overwritten (circular), depth stays RAS_DEPTH, overflow set; address <= target.
REQ-021 RET with depth>0: address <= top entry; pop; depth-1.
REQ-022 RET while stack_empty: address <= address+1, depth stays 0, underflow set.
REQ-023 HOLD codes: no state change, no flag change.
REQ-024 overflow and underflow SHALL stay set until reset; they are never cleared by operations.
REQ-025 Stack storage SHALL be LIFO: successive RETs return the pushed addresses in reverse order, the most recent surviving entries after overflow.

Reset
REQ-026 reset SHALL take priority over enable and op.
REQ-027 On reset: address=RESET_ADDR, depth=0, overflow=0, underflow=0; stack contents are don't-care.
REQ-028 Reset asserted mid-sequence (any depth) SHALL discard all pending return addresses within one edge.

Structure
REQ-029 Package pc_seq_pkg SHALL hold the op encodings (OP_INC, OP_JUMP, OP_BRANCH, OP_CALL, OP_RET) and the default parameter values.
REQ-030 The stack SHALL be a sub-module ras_stack (push, pop, push_data, top, depth, full, empty; circular overwrite on push-when-full).
REQ-031 Next-address selection SHALL be one combinational mux feeding a single address register.

Verification
REQ-032 Reset, then 10 cycles INC with enable=1 -> address 00..0A; then enable=0 for 5 cycles -> address held at 0A.
REQ-033 address=FE, INC x3 -> FF, 00, 01; BRANCH offset=FD from 10 -> 0D; offset=05 from FE -> 03.
REQ-034 From 20: CALL 40, CALL 60, RET, RET -> 40, 60, 41, 21; depth 1,2,1,0.
REQ-035 RAS_DEPTH=4: five CALLs from 00 targeting 10,20,30,40,50 -> overflow=1, depth=4; four RETs -> 41, 31, 21, 11; fifth RET -> underflow=1, address 12.
REQ-036 depth=3, assert reset with op=RET -> address=RESET_ADDR, depth=0, flags 0; following RET -> underflow=1, address RESET_ADDR+1.
REQ-037 op=101..111 with enable=1 and op=CALL with enable=0 -> no change to address, depth or flags.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - op encodings and default parameters for the program sequencer
package pc_seq_pkg;

  localparam logic [2:0] OP_INC    = 3'b000;
  localparam logic [2:0] OP_JUMP   = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  localparam int          DEF_ADDR_W     = 8;
  localparam int          DEF_RAS_DEPTH  = 4;
  localparam logic [31:0] DEF_RESET_ADDR = 32'h0;

endpackage

// File: rtl/program_sequencer_if.sv
// rtl/program_sequencer_if.sv - control and status bundle between a controller and the sequencer
interface program_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH
);
  localparam int DEPTH_W = $clog2(RAS_DEPTH + 1);

  logic              enable;
  logic [2:0]        op;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] address;
  logic [DEPTH_W-1:0] depth;
  logic              stack_full;
  logic              stack_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output enable, op, target, offset,
    input  address, depth, stack_full, stack_empty, overflow, underflow
  );

  modport slave (
    input  enable, op, target, offset,
    output address, depth, stack_full, stack_empty, overflow, underflow
  );

endinterface

// File: rtl/program_sequencer_ras_stack.sv
// rtl/program_sequencer_ras_stack.sv - circular return-address stack; push when full drops the oldest entry
module ras_stack
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH,
  localparam int DEPTH_W  = $clog2(RAS_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [ADDR_W-1:0]  push_data,
  output logic [ADDR_W-1:0]  top,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  // The slot just above the top is the oldest one once the ring is full.
  assign wr_ptr = top_ptr + PTR_W'(1);
  assign full   = (depth == DEPTH_W'(RAS_DEPTH));
  assign empty  = (depth == '0);
  assign top    = mem[top_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      top_ptr <= '0;
      depth   <= '0;
    end else if (push) begin
      top_ptr <= wr_ptr;
      if (!full) depth <= depth + DEPTH_W'(1);
    end else if (pop && !empty) begin
      top_ptr <= top_ptr - PTR_W'(1);
      depth   <= depth - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - program address sequencer with jump, branch, call and return
module program_sequencer
  import pc_seq_pkg::*;
#(
  parameter int          ADDR_W     = DEF_ADDR_W,
  parameter int          RAS_DEPTH  = DEF_RAS_DEPTH,
  parameter logic [31:0] RESET_ADDR = DEF_RESET_ADDR
) (
  input  logic                clk,
  input  logic                reset,
  program_sequencer_if.slave  bus
);
  localparam int DEPTH_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  next_addr;
  logic [ADDR_W-1:0]  seq_addr;
  logic [ADDR_W-1:0]  stack_top;
  logic [DEPTH_W-1:0] depth;
  logic               full;
  logic               empty;
  logic               is_call;
  logic               is_ret;
  logic               push;
  logic               pop;
  logic               ovf_q;
  logic               unf_q;

  assign seq_addr = addr_q + ADDR_W'(1);
  assign is_call  = bus.enable && (bus.op == OP_CALL);
  assign is_ret   = bus.enable && (bus.op == OP_RET);
  assign push     = is_call;
  assign pop      = is_ret && !empty;

  always_comb begin
    next_addr = addr_q;
    case (bus.op)
      OP_INC:    next_addr = seq_addr;
      OP_JUMP:   next_addr = bus.target;
      OP_BRANCH: next_addr = addr_q + bus.offset;
      OP_CALL:   next_addr = bus.target;
      // An empty stack turns RET into a plain step forward.
      OP_RET:    next_addr = empty ? seq_addr : stack_top;
      default:   next_addr = addr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= ADDR_W'(RESET_ADDR);
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else if (bus.enable) begin
      addr_q <= next_addr;
      if (is_call && full) ovf_q <= 1'b1;
      if (is_ret && empty) unf_q <= 1'b1;
    end
  end

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (seq_addr),
    .top       (stack_top),
    .depth     (depth),
    .full      (full),
    .empty     (empty)
  );

  assign bus.address     = addr_q;
  assign bus.depth       = depth;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - vector table and stack-model checks for program_sequencer
module tb_program_sequencer;
  import pc_seq_pkg::*;

  localparam int AW = 8;
  localparam int RD = 4;
  localparam int DW = $clog2(RD + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_sequencer_if #(.ADDR_W(AW), .RAS_DEPTH(RD)) bus ();

  program_sequencer #(
    .ADDR_W     (AW),
    .RAS_DEPTH  (RD),
    .RESET_ADDR (32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          rst;
    logic          en;
    logic [2:0]    op;
    logic [AW-1:0] tgt;
    logic [AW-1:0] off;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          eo;
    logic          eu;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          o;
    logic          u;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  function automatic void v(input logic rst, input logic en, input logic [2:0] op,
                            input logic [AW-1:0] tgt, input logic [AW-1:0] off,
                            input logic [AW-1:0] ea, input int ed,
                            input logic eo, input logic eu);
    vec_t x;
    x.rst = rst; x.en = en; x.op = op; x.tgt = tgt; x.off = off;
    x.ea = ea; x.ed = DW'(ed); x.eo = eo; x.eu = eu;
    tv.push_back(x);
  endfunction

  task automatic check(input string nm);
    exp_t e;
    logic ok;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty, got addr=%h, required an expected entry", nm, bus.address);
      return;
    end
    e = sb.pop_front();
    total++;
    ok = (bus.address == e.a) && (bus.depth == e.d) && (bus.overflow == e.o) &&
         (bus.underflow == e.u) && (bus.stack_full == (e.d == DW'(RD))) &&
         (bus.stack_empty == (e.d == '0));
    if (ok) passed++;
    else $display("FAIL %s: got addr=%h depth=%0d ovf=%b unf=%b full=%b empty=%b, required addr=%h depth=%0d ovf=%b unf=%b full=%b empty=%b",
                  nm, bus.address, bus.depth, bus.overflow, bus.underflow, bus.stack_full,
                  bus.stack_empty, e.a, e.d, e.o, e.u, (e.d == DW'(RD)), (e.d == '0));
  endtask

  task automatic step(input vec_t x, input string nm);
    exp_t e;
    reset      = x.rst;
    bus.enable = x.en;
    bus.op     = x.op;
    bus.target = x.tgt;
    bus.offset = x.off;
    e.a = x.ea; e.d = x.ed; e.o = x.eo; e.u = x.eu;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(nm);
  endtask

  initial begin
    logic [AW-1:0] m_addr;
    logic          m_ovf;
    logic          m_unf;
    logic [AW-1:0] m_stk[$];
    vec_t          x;

    reset = 1'b1; bus.enable = 1'b0; bus.op = OP_INC; bus.target = '0; bus.offset = '0;

    // count up from reset, then hold with enable low
    v(1, 1, OP_INC, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    for (int i = 1; i <= 10; i++) v(0, 1, OP_INC, 8'h00, 8'h00, AW'(i), 0, 0, 0);
    for (int i = 0; i < 5; i++)   v(0, 0, OP_INC, 8'h00, 8'h00, 8'h0A, 0, 0, 0);
    // wrap and relative branches
    v(0, 1, OP_JUMP,   8'hFE, 8'h00, 8'hFE, 0, 0, 0);
    v(0, 1, OP_INC,    8'h00, 8'h00, 8'hFF, 0, 0, 0);
    v(0, 1, OP_INC,    8'h00, 8'h00, 8'h00, 0, 0, 0);
    v(0, 1, OP_INC,    8'h00, 8'h00, 8'h01, 0, 0, 0);
    v(0, 1, OP_JUMP,   8'h10, 8'h00, 8'h10, 0, 0, 0);
    v(0, 1, OP_BRANCH, 8'h00, 8'hFD, 8'h0D, 0, 0, 0);
    v(0, 1, OP_JUMP,   8'hFE, 8'h00, 8'hFE, 0, 0, 0);
    v(0, 1, OP_BRANCH, 8'h00, 8'h05, 8'h03, 0, 0, 0);
    v(0, 1, OP_BRANCH, 8'h00, 8'h00, 8'h03, 0, 0, 0);
    v(0, 1, OP_BRANCH, 8'h00, 8'hFF, 8'h02, 0, 0, 0);
    // nested call and return
    v(0, 1, OP_JUMP, 8'h20, 8'h00, 8'h20, 0, 0, 0);
    v(0, 1, OP_CALL, 8'h40, 8'h00, 8'h40, 1, 0, 0);
    v(0, 1, OP_CALL, 8'h60, 8'h00, 8'h60, 2, 0, 0);
    v(0, 1, OP_RET,  8'h00, 8'h00, 8'h41, 1, 0, 0);
    v(0, 1, OP_RET,  8'h00, 8'h00, 8'h21, 0, 0, 0);
    // hold codes and disabled call/ret with an entry on the stack
    v(0, 1, OP_CALL, 8'h70, 8'h00, 8'h70, 1, 0, 0);
    v(0, 1, 3'b101,  8'h99, 8'h11, 8'h70, 1, 0, 0);
    v(0, 1, 3'b110,  8'h99, 8'h11, 8'h70, 1, 0, 0);
    v(0, 1, 3'b111,  8'h99, 8'h11, 8'h70, 1, 0, 0);
    v(0, 0, OP_CALL, 8'h99, 8'h00, 8'h70, 1, 0, 0);
    v(0, 0, OP_RET,  8'h00, 8'h00, 8'h70, 1, 0, 0);
    v(0, 1, OP_RET,  8'h00, 8'h00, 8'h22, 0, 0, 0);
    // overflow drops the oldest entry, underflow on the extra return
    v(1, 0, OP_INC,  8'h00, 8'h00, 8'h00, 0, 0, 0);
    v(0, 1, OP_CALL, 8'h10, 8'h00, 8'h10, 1, 0, 0);
    v(0, 1, OP_CALL, 8'h20, 8'h00, 8'h20, 2, 0, 0);
    v(0, 1, OP_CALL, 8'h30, 8'h00, 8'h30, 3, 0, 0);
    v(0, 1, OP_CALL, 8'h40, 8'h00, 8'h40, 4, 0, 0);
    v(0, 1, OP_CALL, 8'h50, 8'h00, 8'h50, 4, 1, 0);
    v(0, 1, OP_RET,  8'h00, 8'h00, 8'h41, 3, 1, 0);
    v(0, 1, OP_RET,  8'h00, 8'h00, 8'h31, 2, 1, 0);
    v(0, 1, OP_RET,  8'h00, 8'h00, 8'h21, 1, 1, 0);
    v(0, 1, OP_RET,  8'h00, 8'h00, 8'h11, 0, 1, 0);
    v(0, 1, OP_RET,  8'h00, 8'h00, 8'h12, 0, 1, 1);
    v(0, 1, OP_INC,  8'h00, 8'h00, 8'h13, 0, 1, 1);
    v(0, 1, 3'b110,  8'h00, 8'h00, 8'h13, 0, 1, 1);
    // reset mid-stack beats enable and op
    v(1, 1, OP_INC,  8'h00, 8'h00, 8'h00, 0, 0, 0);
    v(0, 1, OP_CALL, 8'h10, 8'h00, 8'h10, 1, 0, 0);
    v(0, 1, OP_CALL, 8'h20, 8'h00, 8'h20, 2, 0, 0);
    v(0, 1, OP_CALL, 8'h30, 8'h00, 8'h30, 3, 0, 0);
    v(1, 1, OP_RET,  8'h00, 8'h00, 8'h00, 0, 0, 0);
    v(0, 1, OP_RET,  8'h00, 8'h00, 8'h01, 0, 0, 1);

    for (int i = 0; i < tv.size(); i++) step(tv[i], $sformatf("vec%0d", i));

    // deep call chain against a bounded LIFO model
    x.rst = 1; x.en = 0; x.op = OP_INC; x.tgt = '0; x.off = '0;
    x.ea = '0; x.ed = '0; x.eo = 0; x.eu = 0;
    step(x, "chain_reset");
    m_addr = '0; m_ovf = 0; m_unf = 0;
    for (int i = 0; i < 9; i++) begin
      x.rst = 0; x.en = 1; x.op = OP_CALL; x.tgt = AW'(8'h80 + 8 * i);
      m_stk.push_back(m_addr + AW'(1));
      if (m_stk.size() > RD) begin
        void'(m_stk.pop_front());
        m_ovf = 1;
      end
      m_addr = x.tgt;
      x.ea = m_addr; x.ed = DW'(m_stk.size()); x.eo = m_ovf; x.eu = m_unf;
      step(x, $sformatf("chain_call%0d", i));
    end
    for (int i = 0; i < RD + 1; i++) begin
      x.rst = 0; x.en = 1; x.op = OP_RET; x.tgt = '0;
      if (m_stk.size() > 0) m_addr = m_stk.pop_back();
      else begin
        m_addr = m_addr + AW'(1);
        m_unf  = 1;
      end
      x.ea = m_addr; x.ed = DW'(m_stk.size()); x.eo = m_ovf; x.eu = m_unf;
      step(x, $sformatf("chain_ret%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
